dlfloat_dot_seq: RTL and testbench

Sequencer that turns the DLFloat16 multiply-accumulate datapath into a length-N dot-product engine. It takes a start command with a vector length, accepts N operand pairs over a valid/ready stream, and feeds them to the MAC. It clears the accumulator before each job, drains the MAC pipeline after the last pair, and returns the accumulated DLFloat16 result over a valid/ready output. It sits between the byte-level I/O wrappers and a MAC that has a synchronous accumulator-clear input.

---
 rtl/dlfloat_pkg.sv | 18 +
 rtl/dlfloat_sat_cnt.sv | 29 ++
 rtl/dlfloat_dot_seq.sv | 136 +++++++++++++
 tb/tb_dlfloat_dot_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 constants and sequencer state encoding for the dot-product engine.
package dlfloat_pkg;

  localparam int DLF_W    = 16;
  localparam int DLF_BIAS = 31;

  localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;
  localparam logic [DLF_W-1:0] DLF_NAN  = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    OUT
  } seq_state_t;

endpackage

// File: rtl/dlfloat_sat_cnt.sv
// Loadable saturating counter; counts up to all-ones or down to zero and then holds.
module dlfloat_sat_cnt #(
  parameter int W    = 16,
  parameter bit DOWN = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count
);

  // A load always wins over a step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      if (DOWN) begin
        if (count != '0) count <= count - W'(1);
      end else begin
        if (count != '1) count <= count + W'(1);
      end
    end
  end

endmodule

// File: rtl/dlfloat_dot_seq.sv
// Length-N dot-product sequencer in front of a DLFloat16 MAC with synchronous accumulator clear.
// Optional DLFLOAT_SEQ_STALL_CNT_EN adds a saturating count of input-starved RUN cycles.
module dlfloat_dot_seq
  import dlfloat_pkg::*;
#(
  parameter int LEN_W    = 8,
  parameter int MULT_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DLF_W-1:0] a_in,
  input  logic [DLF_W-1:0] b_in,
  output logic [DLF_W-1:0] mac_a,
  output logic [DLF_W-1:0] mac_b,
  output logic             mac_clr,
  input  logic [DLF_W-1:0] mac_acc,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DLF_W-1:0] result
`ifdef DLFLOAT_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int DRAIN_W = 8;

  seq_state_t         state;
  logic [LEN_W-1:0]   rem;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               transfer;
  logic               last_xfer;
  logic               start_acc;

  assign transfer  = in_valid & in_ready;
  assign last_xfer = transfer && (rem == LEN_W'(1));
  assign start_acc = (state == IDLE) && start;

  // Drain waits for the last product to pass the multiplier and land in the accumulator.
  dlfloat_sat_cnt #(
    .W    (DRAIN_W),
    .DOWN (1'b1)
  ) u_drain_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (last_xfer),
    .load_val (DRAIN_W'(MULT_LAT + 1)),
    .en       (state == DRAIN),
    .count    (drain_cnt)
  );

`ifdef DLFLOAT_SEQ_STALL_CNT_EN
  dlfloat_sat_cnt #(
    .W    (16),
    .DOWN (1'b0)
  ) u_stall_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_acc),
    .load_val (16'h0000),
    .en       ((state == RUN) && !in_valid),
    .count    (stall_cnt)
  );
`endif

  // Non-transfer edges push zero operands so bubbles add nothing to the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem       <= '0;
      mac_a     <= DLF_ZERO;
      mac_b     <= DLF_ZERO;
      mac_clr   <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      result    <= DLF_ZERO;
    end else begin
      mac_a   <= DLF_ZERO;
      mac_b   <= DLF_ZERO;
      mac_clr <= 1'b0;
      if (transfer) begin
        mac_a <= a_in;
        mac_b <= b_in;
        rem   <= rem - LEN_W'(1);
      end
      case (state)
        IDLE: begin
          if (start_acc) begin
            busy <= 1'b1;
            if (len != '0) begin
              state   <= CLEAR;
              rem     <= len;
              mac_clr <= 1'b1;
            end else begin
              state     <= OUT;
              result    <= DLF_ZERO;
              out_valid <= 1'b1;
            end
          end
        end
        CLEAR: begin
          state    <= RUN;
          in_ready <= 1'b1;
        end
        RUN: begin
          if (last_xfer) begin
            state    <= DRAIN;
            in_ready <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state     <= OUT;
            result    <= mac_acc;
            out_valid <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dlfloat_dot_seq.sv
// Self-checking bench for dlfloat_dot_seq with a real-arithmetic MAC model and dot-product reference.
module tb_dlfloat_dot_seq;
  import dlfloat_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a_in = 16'h0;
  logic [15:0] b_in = 16'h0;
  logic [15:0] mac_a, mac_b;
  logic        mac_clr;
  logic [15:0] mac_acc;
  logic        busy, out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
`ifdef DLFLOAT_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad = 0;
  int clr_seen = 0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];

  always #5 clk = ~clk;

  dlfloat_dot_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_clr   (mac_clr),
    .mac_acc   (mac_acc),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef DLFLOAT_SEQ_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  function automatic real dec(input logic [15:0] x);
    real m;
    int  e;
    if (x[14:9] == 6'd0) return 0.0;
    m = 1.0 + real'(x[8:0]) / 512.0;
    e = int'(x[14:9]) - DLF_BIAS;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[15] ? -m : m;
  endfunction

  function automatic logic [15:0] enc(input real v);
    real        m;
    int         e;
    logic       s;
    logic [8:0] f;
    if (v == 0.0) return DLF_ZERO;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    f = 9'($rtoi((m - 1.0) * 512.0));
    return {s, 6'(e + DLF_BIAS), f};
  endfunction

  // Expected job result straight from the operand lists: NaN if any operand is NaN, else the exact sum.
  function automatic logic [15:0] refDot();
    real sum = 0.0;
    foreach (qa[i]) begin
      if (qa[i] == DLF_NAN || qb[i] == DLF_NAN) return DLF_NAN;
      sum = sum + dec(qa[i]) * dec(qb[i]);
    end
    return enc(sum);
  endfunction

  function automatic logic [15:0] randOp();
    real v;
    v = real'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 1) v = -v;
    return enc(v);
  endfunction

  // Environment MAC: one multiplier stage, one accumulator stage, sticky NaN.
  real prod = 0.0;
  real acc = 0.0;
  bit  prod_nan = 1'b0;
  bit  acc_nan = 1'b0;
  always @(posedge clk) begin
    if (mac_clr) begin
      acc     <= 0.0;
      acc_nan <= 1'b0;
    end else begin
      acc     <= acc + prod;
      acc_nan <= acc_nan | prod_nan;
    end
    prod     <= dec(mac_a) * dec(mac_b);
    prod_nan <= (mac_a == DLF_NAN) || (mac_b == DLF_NAN);
  end
  assign mac_acc = acc_nan ? DLF_NAN : enc(acc);

  always @(negedge clk) if (mac_clr) clr_seen++;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp_val);
    total++;
    assert (obs === exp_val) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, obs, exp_val);
    end
  endtask

  // Runs one job from start to the out_ready handshake; overlap raises start alongside out_ready.
  task automatic applyStimulus(input int n, input int gap, input bit overlap);
    logic [15:0] exp_res;
    int lat;
    int wait_cnt;
    exp_res  = refDot();
    clr_seen = 0;
    start = 1'b1;
    len   = 8'(n);
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", 16'(busy), 16'h1);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      a_in = qa[i];
      b_in = qb[i];
      wait_cnt = 0;
      while (!in_ready && wait_cnt < 20) begin
        @(negedge clk);
        wait_cnt++;
      end
      if (!in_ready) checkOutput("in_ready_timeout", 16'(in_ready), 16'h1);
      @(negedge clk);
      in_valid = 1'b0;
      a_in = 16'h0;
      b_in = 16'h0;
      checkOutput("mac_a_xfer", mac_a, qa[i]);
      checkOutput("mac_b_xfer", mac_b, qb[i]);
      if (i < n - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          checkOutput("mac_a_bubble", mac_a, DLF_ZERO);
          checkOutput("mac_b_bubble", mac_b, DLF_ZERO);
        end
      end
    end
    if (n > 0) checkOutput("in_ready_after_last", 16'(in_ready), 16'h0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", 16'(lat), (n > 0) ? 16'd3 : 16'd0);
    checkOutput("result", result, exp_res);
    checkOutput("clr_pulses", 16'(clr_seen), (n > 0) ? 16'd1 : 16'd0);
`ifdef DLFLOAT_SEQ_STALL_CNT_EN
    checkOutput("stall_cnt", stall_cnt, 16'((n > 0) ? gap * (n - 1) : 0));
`endif
    @(negedge clk);
    checkOutput("hold_valid", 16'(out_valid), 16'h1);
    checkOutput("hold_result", result, exp_res);
    out_ready = 1'b1;
    if (overlap) begin
      start = 1'b1;
      len   = 8'd1;
    end
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("out_valid_clear", 16'(out_valid), 16'h0);
    checkOutput("idle_busy", 16'(busy), 16'h0);
  endtask

  initial begin
    int n;
    int gap;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 16'(in_ready), 16'h0);
    checkOutput("rst_busy", 16'(busy), 16'h0);
    checkOutput("rst_out_valid", 16'(out_valid), 16'h0);
    checkOutput("rst_result", result, DLF_ZERO);
    checkOutput("rst_mac_clr", 16'(mac_clr), 16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] back-to-back len=2");
    qa = '{16'h3E00, 16'h4000};
    qb = '{16'h4000, 16'h4100};
    applyStimulus(2, 0, 1'b0);

    $display("[TB] len=2 with 4-cycle gap");
    applyStimulus(2, 4, 1'b0);

    $display("[TB] len=0");
    qa = {};
    qb = {};
    applyStimulus(0, 0, 1'b0);

    $display("[TB] NaN operand");
    qa = '{16'h4000, 16'hFFFF, 16'h3E00};
    qb = '{16'h4000, 16'h4000, 16'h3E00};
    applyStimulus(3, 1, 1'b0);
    checkOutput("nan_result", result, DLF_NAN);

    $display("[TB] consecutive jobs with early start");
    qa = '{16'h3E00, 16'h4000};
    qb = '{16'h4000, 16'h4100};
    applyStimulus(2, 0, 1'b1);
    qa = '{16'h3E00};
    qb = '{16'h3E00};
    applyStimulus(1, 0, 1'b0);
    checkOutput("job2_result", result, 16'h3E00);

    $display("[TB] reset mid-RUN");
    start = 1'b1;
    len   = 8'd5;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    a_in = 16'h4000;
    b_in = 16'h4000;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready", 16'(in_ready), 16'h0);
    checkOutput("mid_rst_busy", 16'(busy), 16'h0);
    checkOutput("mid_rst_out_valid", 16'(out_valid), 16'h0);
    checkOutput("mid_rst_mac_a", mac_a, DLF_ZERO);
    checkOutput("mid_rst_mac_b", mac_b, DLF_ZERO);
    checkOutput("mid_rst_result", result, DLF_ZERO);
    in_valid = 1'b0;
    a_in = 16'h0;
    b_in = 16'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    qa = '{16'h4000, 16'h4100};
    qb = '{16'h4100, 16'h3E00};
    applyStimulus(2, 0, 1'b0);

    $display("[TB] random jobs");
    for (int j = 0; j < 8; j++) begin
      n   = $urandom_range(1, 6);
      gap = $urandom_range(0, 2);
      qa = {};
      qb = {};
      for (int i = 0; i < n; i++) begin
        qa.push_back(randOp());
        qb.push_back(randOp());
      end
      applyStimulus(n, gap, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule
